// File: rtl/prod_accum4_if.sv
// Handshake bundle for prod_accum4: product stream in, frame result out.
interface prod_accum4_if #(
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_p;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [7:0]       out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_p, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/prod_accum4.sv
// Accumulates up to N_TERMS 8-bit products per frame and holds the frame sum,
// term count and overflow flag until the downstream handshake.
module prod_accum4 #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 16
) (
  input logic         clk,
  input logic         rst_n,
  prod_accum4_if.slave bus
);

  typedef enum logic {ACC, HOLD} state_t;

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf;
  logic [ACC_W-1:0] sum_q;
  logic [7:0]       count_q;
  logic             ovf_q;
  logic             in_ready_int;
  logic             out_valid_int;
  logic             accept;
  logic             frame_end;
  logic [ACC_W:0]   sum;

  assign accept    = bus.in_valid && in_ready_int;
  assign sum       = {1'b0, acc} + (ACC_W + 1)'(bus.in_p);
  assign frame_end = accept && (bus.in_last || (cnt == 8'(N_TERMS - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACC:     if (frame_end) state_next = HOLD;
      HOLD:    if (bus.out_ready) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  always_comb begin
    in_ready_int  = (state == ACC);
    out_valid_int = (state == HOLD);
  end

  // The running accumulator is cleared as the frame closes, so the
  // next frame starts from zero and cnt never reaches N_TERMS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (frame_end) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      sum_q   <= sum[ACC_W-1:0];
      count_q <= cnt + 8'd1;
      ovf_q   <= ovf | sum[ACC_W];
    end else if (accept) begin
      acc <= sum[ACC_W-1:0];
      cnt <= cnt + 8'd1;
      ovf <= ovf | sum[ACC_W];
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_sum   = sum_q;
  assign bus.out_count = count_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_prod_accum4.sv
// Directed bench for prod_accum4: default, 8-bit-overflow and single-term configurations.
module tb_prod_accum4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  prod_accum4_if #(.ACC_W(16)) bus_def ();
  prod_accum4_if #(.ACC_W(8))  bus_ovf ();
  prod_accum4_if #(.ACC_W(16)) bus_one ();

  prod_accum4 #(.N_TERMS(4), .ACC_W(16)) u_def (.clk(clk), .rst_n(rst_n), .bus(bus_def));
  prod_accum4 #(.N_TERMS(2), .ACC_W(8))  u_ovf (.clk(clk), .rst_n(rst_n), .bus(bus_ovf));
  prod_accum4 #(.N_TERMS(1), .ACC_W(16)) u_one (.clk(clk), .rst_n(rst_n), .bus(bus_one));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] p, input logic last,
                               input logic ordy);
    bus_def.in_valid  = v;
    bus_def.in_p      = p;
    bus_def.in_last   = last;
    bus_def.out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkDefault(input string tag, input logic vld, input logic rdy,
                              input logic [15:0] s, input logic [7:0] c, input logic o);
    checkOutput({tag, ".out_valid"}, 32'(bus_def.out_valid), 32'(vld));
    checkOutput({tag, ".in_ready"},  32'(bus_def.in_ready),  32'(rdy));
    checkOutput({tag, ".out_sum"},   32'(bus_def.out_sum),   32'(s));
    checkOutput({tag, ".out_count"}, 32'(bus_def.out_count), 32'(c));
    checkOutput({tag, ".out_ovf"},   32'(bus_def.out_ovf),   32'(o));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    bus_ovf.in_valid = 1'b0; bus_ovf.in_p = 8'd0; bus_ovf.in_last = 1'b0; bus_ovf.out_ready = 1'b1;
    bus_one.in_valid = 1'b0; bus_one.in_p = 8'd0; bus_one.in_last = 1'b0; bus_one.out_ready = 1'b1;

    // Reset, two accepts, then reset mid-frame
    tick();
    tick();
    checkDefault("reset", 1'b0, 1'b1, 16'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'd225, 1'b0, 1'b1);
    tick();
    checkOutput("midframe.valid1", 32'(bus_def.out_valid), 32'd0);
    applyStimulus(1'b1, 8'd15, 1'b0, 1'b1);
    tick();
    checkOutput("midframe.valid2", 32'(bus_def.out_valid), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    checkDefault("midreset", 1'b0, 1'b1, 16'd0, 8'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'd1, 1'b0, 1'b1);
      tick();
      if (i < 3) checkOutput("ones.early_valid", 32'(bus_def.out_valid), 32'd0);
    end
    checkDefault("ones", 1'b1, 1'b0, 16'd4, 8'd4, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    tick();
    checkOutput("ones.release", 32'(bus_def.in_ready), 32'd1);

    // Full frame with the N_TERMS limit closing it
    applyStimulus(1'b1, 8'd225, 1'b0, 1'b1); tick();
    applyStimulus(1'b1, 8'd0,   1'b0, 1'b1); tick();
    applyStimulus(1'b1, 8'd15,  1'b0, 1'b1); tick();
    checkOutput("full.early_valid", 32'(bus_def.out_valid), 32'd0);
    applyStimulus(1'b1, 8'd100, 1'b0, 1'b1); tick();
    checkDefault("full", 1'b1, 1'b0, 16'd340, 8'd4, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    tick();
    checkDefault("full.after", 1'b0, 1'b1, 16'd340, 8'd4, 1'b0);

    // Early frame end via in_last
    applyStimulus(1'b1, 8'd9, 1'b0, 1'b1); tick();
    applyStimulus(1'b1, 8'd6, 1'b1, 1'b1); tick();
    checkDefault("early", 1'b1, 1'b0, 16'd15, 8'd2, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    tick();

    // Backpressure: result held, in_valid in HOLD has no effect
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0); tick();
    checkDefault("bp.frame", 1'b1, 1'b0, 16'd10, 8'd2, 1'b0);
    applyStimulus(1'b1, 8'd7, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkDefault("bp.hold", 1'b1, 1'b0, 16'd10, 8'd2, 1'b0);
    end
    applyStimulus(1'b1, 8'd7, 1'b0, 1'b1);
    tick();
    checkOutput("bp.release_valid", 32'(bus_def.out_valid), 32'd0);
    checkOutput("bp.release_ready", 32'(bus_def.in_ready), 32'd1);
    applyStimulus(1'b1, 8'd7, 1'b1, 1'b1);
    tick();
    checkDefault("bp.next", 1'b1, 1'b0, 16'd7, 8'd1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    tick();

    // Overflow with ACC_W=8, N_TERMS=2
    bus_ovf.in_valid = 1'b1; bus_ovf.in_p = 8'd225;
    tick();
    tick();
    bus_ovf.in_valid = 1'b0;
    checkOutput("ovf.valid", 32'(bus_ovf.out_valid), 32'd1);
    checkOutput("ovf.sum",   32'(bus_ovf.out_sum),   32'd194);
    checkOutput("ovf.count", 32'(bus_ovf.out_count), 32'd2);
    checkOutput("ovf.flag",  32'(bus_ovf.out_ovf),   32'd1);
    tick();
    bus_ovf.in_valid = 1'b1; bus_ovf.in_p = 8'd1;
    tick();
    tick();
    bus_ovf.in_valid = 1'b0;
    checkOutput("ovf2.sum",  32'(bus_ovf.out_sum), 32'd2);
    checkOutput("ovf2.flag", 32'(bus_ovf.out_ovf), 32'd0);
    tick();

    // N_TERMS=1 streaming: accepts alternate with HOLD cycles
    bus_one.in_valid = 1'b1;
    for (int v = 3; v <= 5; v++) begin
      bus_one.in_p = 8'(v);
      tick();
      checkOutput("one.valid", 32'(bus_one.out_valid), 32'd1);
      checkOutput("one.sum",   32'(bus_one.out_sum),   32'(v));
      checkOutput("one.count", 32'(bus_one.out_count), 32'd1);
      tick();
      checkOutput("one.ready", 32'(bus_one.in_ready),  32'd1);
    end
    bus_one.in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prod_accum4.md
# prod_accum4

Sequential accumulate stage placed directly downstream of the 4x4 unsigned multiplier. It consumes a stream of 8-bit products over a valid/ready handshake and sums up to N_TERMS products per frame into a wider accumulator. It then presents the frame sum, term count and an overflow flag on an output valid/ready handshake. It turns the combinational multiplier into a dot-product / MAC datapath and registers its result.

## Interface

- N_TERMS, 4, maximum products per frame; legal range 1..255
- ACC_W, 16, accumulator and sum width; legal range 8..32

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset; assertion clears all state immediately; deassertion is used synchronously to clk
- in_valid  in  1  in_p is valid this cycle
- in_ready  out  1  stage can accept a product this cycle
- in_p  in  8  unsigned product from the multiplier (P output, 0..225 in practice, full 0..255 legal)
- in_last  in  1  qualified by in_valid; marks the final product of the frame
- out_valid  out  1  frame result valid
- out_ready  in  1  downstream accepts the frame result
- out_sum  out  ACC_W  frame sum, modulo 2^ACC_W
- out_count  out  8  number of products summed in the frame (1..N_TERMS)
- out_ovf  out  1  frame sum exceeded 2^ACC_W-1 at any accumulation

## Operation

- Two states: ACC and HOLD. Reset state is ACC with acc=0, cnt=0, ovf=0.
- Reset values:
  - in_ready=1, out_valid=0
  - out_sum=0, out_count=0, out_ovf=0
- ACC state:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid and in_ready are both high.
  - On accept: acc <= acc + zero-extended in_p (ACC_W+1-bit add); cnt <= cnt+1; ovf <= ovf OR carry-out.
- Frame end is an accept where in_last=1 or cnt==N_TERMS-1. On frame end:
  - out_sum <= acc + in_p (truncated); out_count <= cnt+1; out_ovf <= ovf OR carry.
  - Next state is HOLD.
- HOLD state:
  - in_ready=0, out_valid=1.
  - out_sum, out_count and out_ovf stay stable until the handshake.
  - On out_valid and out_ready: acc <= 0, cnt <= 0, ovf <= 0, next state ACC.
- in_last on a non-accepted cycle (in_valid=0) is ignored.
- With N_TERMS=1, every accept ends a frame.
- Frame-boundary wrap: cnt never exceeds N_TERMS-1, and the N_TERMS-th accept always ends the frame even if in_last=0.
- Overflow: the sum wraps modulo 2^ACC_W and out_ovf is sticky for the frame only.
- Reset asserted mid-frame or in HOLD:
  - The partial frame is discarded and no output is produced.
  - Outputs take their reset values in the same instant.

## Timing

- in_ready is a registered-state decode. It is combinational from state only, never from in_valid or out_ready.
- Latency:
  - out_valid rises on the clock edge that accepts the frame-ending product, so it is visible the next cycle.
  - Last accept to result is 1 cycle.
- Throughput:
  - One product per cycle in ACC.
  - A frame of k terms occupies k accept cycles plus at least 1 HOLD cycle, so a frame takes at least k+1 cycles.
- In HOLD with out_ready=1: handshake at that edge, ACC on the next cycle, and in_ready=1 on the next cycle. There is no dead cycle beyond the single HOLD cycle.
- Backpressure: out_ready may stay low indefinitely. The stage holds the result and keeps in_ready=0, and upstream must hold in_valid/in_p.
- in_valid may be asserted in HOLD. It is not accepted and carries no side effect.

## Test plan

- Reset mid-frame:
  - Stimulus: rst_n low for 2 cycles, release, then accept 2 products (225, 15), then assert rst_n low mid-frame.
  - Required response: outputs return to reset values immediately, with out_valid never asserted.
  - Then, after release, feed 4 products of 1 each: out_sum=4, out_count=4.
- Full frame with defaults:
  - Stimulus: in_p = 225, 0, 15, 100 back-to-back, out_ready=1.
  - Required response: out_valid one cycle after the 4th accept, out_sum=340, out_count=4, out_ovf=0, in_ready=0 for exactly that cycle.
- Early frame end:
  - Stimulus: in_p = 9, 6 with in_last on the second product.
  - Required response: out_sum=15, out_count=2. The next frame then starts with acc=0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after the frame ends, with in_valid held high and in_p=7.
  - Required response: out_sum stable, in_ready=0, and no accept occurs.
  - On releasing out_ready: one handshake, then 7 is accepted as the first term of the next frame.
- Overflow (ACC_W=8, N_TERMS=2):
  - Stimulus: in_p = 225, 225.
  - Required response: out_sum=194 (450 mod 256), out_ovf=1.
  - Next frame (1, 1): out_sum=2, out_ovf=0.
- N_TERMS=1 streaming:
  - Stimulus: continuous in_valid with in_p = 3, 4, 5 and out_ready=1.
  - Required response: each value is produced with out_count=1, and accepts alternate with HOLD cycles.
